dual_port_ram_be: RTL and testbench
===================================

Name: dual_port_ram_be

Overview:
Parametrised true dual-clock simple dual-port RAM: one write port on wclk, one read port on rclk. It adds byte-write enables, a selectable read latency (1 or 2) with aligned valid, and a hardware clear engine that zero-fills the array.
It is the general storage primitive for buffers and register files that cross between the write and read clock domains.

Parameters:
DATA_W, 8, data width in bits; must be a multiple of 8
DEPTH, 32, number of words; need not be a power of two
ADDR_W, 5, address width; must satisfy 2^ADDR_W >= DEPTH
READ_LATENCY, 1, rclk cycles from accepted read to o_data/valid; legal values 1 or 2
NBYTES, DATA_W/8, derived; number of byte lanes

Ports:
rclk  in  1  read clock
wclk  in  1  write clock
rst_n  in  1  reset for both domains; deassertion is synchronised externally per domain
en  in  1  global port enable; gates both read and write
we  in  1  write request (wclk domain)
wbe  in  NBYTES  byte-write enables; bit i covers w_data[8i+7:8i]
w_addr  in  ADDR_W  write address
w_data  in  DATA_W  write data
clr  in  1  clear request, single wclk pulse
clr_busy  out  1  high while the clear engine runs (wclk domain)
re  in  1  read request (rclk domain)
r_addr  in  ADDR_W  read address
o_data  out  DATA_W  read data
valid  out  1  one-cycle strobe that qualifies o_data

Behaviour:
Interface:
- Reset rst_n, asynchronous, active-low. Clock rclk.
- wclk drives the write port and the clear engine.

Reset:
- o_data = 0, valid = 0, clr_busy = 0, clear FSM in IDLE, clear counter = 0.
- Array contents are not reset.

Write (wclk):
- Accepted when en && we && !clr_busy && w_addr < DEPTH.
- For each byte i with wbe[i] = 1, mem[w_addr] byte i <= w_data byte i. Other bytes are unchanged.
- wbe = 0 performs no write.
- w_addr >= DEPTH: write silently dropped.
- User writes that occur while clr_busy = 1 are dropped. There is no queuing.

Read (rclk):
- Accepted when en && re. It is independent of we, since the two ports are distinct.
- READ_LATENCY = 1: o_data <= mem[r_addr] and valid <= 1 on the next rclk edge.
- READ_LATENCY = 2: an extra output register stage. Data and valid both appear 2 edges after acceptance and stay aligned.
- Back-to-back reads give one result per cycle. Valid is pipelined per request, not level-held.
- Non-accepted cycle: valid = 0 at the corresponding output slot. o_data holds its last value.
- r_addr >= DEPTH: o_data = 0, valid = 1.
- Reads are allowed during a clear. They return either old data or zero, depending on clear progress.

Clear engine (wclk):
- FSM states are IDLE and CLEAR.
- IDLE -> CLEAR on clr && en: counter <= 0, clr_busy <= 1 on the same edge.
- In CLEAR, each wclk writes all-zero to mem[counter] and increments the counter.
- On the write to address DEPTH-1: return to IDLE, clr_busy <= 0 on that edge.
- Clear occupies exactly DEPTH wclk cycles.
- clr while busy is ignored; it does not restart the sweep.
- rst_n asserted mid-clear aborts immediately: FSM IDLE, clr_busy = 0. The array is left partially cleared, which is legal.

Collisions:
- A read and a write to the same address in overlapping clock windows return either old or new data; which one is undefined.
- The bench must not check collided data, but valid must still be correct.
- A same-wclk-edge user write and clear are impossible, because busy blocks the user write.

Width rules:
- Address compare is unsigned, full ADDR_W.
- The clear counter is ADDR_W wide and never exceeds DEPTH-1.

Test Plan:
- Reset, then write 0xA5 to addr 3 with wbe = 1, then read addr 3 (READ_LATENCY = 1) -> o_data = 0xA5 with valid high exactly 1 rclk after re; valid = 0 on the following idle cycle.
- DATA_W = 32: write 0x11223344 full to addr 7, then write 0xAABBCCDD with wbe = 4'b0101, then read addr 7 -> o_data = 0x11BB33DD.
- READ_LATENCY = 2: back-to-back reads of addrs 0, 1, 2 preloaded with 5, 6, 7 -> o_data sequence 5, 6, 7 with valid high 2 cycles after each re, 3 consecutive cycles; a gap in re gives a gap in valid.
- DEPTH = 20, ADDR_W = 5: write to addr 25, then read addr 25 -> o_data = 0, valid = 1; addr 19 remains unchanged.
- Fill all words with 0xFF, pulse clr -> clr_busy high for exactly DEPTH wclk cycles; a user write to addr 4 mid-clear is dropped; all reads afterward return 0.
- Pulse clr, assert rst_n low after 10 wclk cycles -> clr_busy = 0, o_data = 0, valid = 0 immediately; after release, addrs 0-9 read 0 and addrs >= 11 still read 0xFF.

Source files
------------

// File: rtl/dual_port_ram_be.sv
// dual_port_ram_be: simple dual-port RAM with separate write (wclk) and read
// (rclk) clocks, per-byte write enables, a selectable read latency of 1 or 2
// rclk cycles with an aligned valid strobe, and a clear engine that
// zero-fills the array one word per wclk cycle.
//
// Ports:
//   rclk, wclk    read / write clocks
//   rst_n         async active-low reset for both domains
//   en            global enable, gates read, write and clear start
//   we, wbe       write request and byte-lane enables (wclk)
//   w_addr,w_data write address / data (wclk)
//   clr           clear request pulse (wclk)
//   clr_busy      high while the clear sweep runs (wclk)
//   re, r_addr    read request and address (rclk)
//   o_data, valid read data and its qualifying strobe (rclk)
module dual_port_ram_be #(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned DEPTH        = 32,
    parameter int unsigned ADDR_W       = 5,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned NBYTES       = DATA_W / 8
) (
    input  logic              rclk,
    input  logic              wclk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              we,
    input  logic [NBYTES-1:0] wbe,
    input  logic [ADDR_W-1:0] w_addr,
    input  logic [DATA_W-1:0] w_data,
    input  logic              clr,
    output logic              clr_busy,
    input  logic              re,
    input  logic [ADDR_W-1:0] r_addr,
    output logic [DATA_W-1:0] o_data,
    output logic              valid
);

    // DEPTH widened by one bit so the full-width unsigned compare works
    // even when DEPTH == 2**ADDR_W.
    localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

    logic [DATA_W-1:0] mem [DEPTH];

    clr_state_t        clr_state;
    logic [ADDR_W-1:0] clr_cnt;

    logic              w_in_range;
    logic              w_accept;
    logic              r_in_range;
    logic              r_accept;
    logic [DATA_W-1:0] rd_word;

    logic [DATA_W-1:0] rd_data1;
    logic              rd_valid1;

    // Request qualification for both ports.
    always_comb begin
        w_in_range = ({1'b0, w_addr} < DEPTH_X);
        r_in_range = ({1'b0, r_addr} < DEPTH_X);
        w_accept   = en && we && !clr_busy && w_in_range;
        r_accept   = en && re;
        rd_word    = '0;
        if (r_in_range) begin
            rd_word = mem[r_addr];
        end
    end

    // Clear engine: one zero write per wclk from address 0 up to DEPTH-1.
    always_ff @(posedge wclk or negedge rst_n) begin
        if (!rst_n) begin
            clr_state <= IDLE;
            clr_cnt   <= '0;
            clr_busy  <= 1'b0;
        end else begin
            case (clr_state)
                IDLE: begin
                    if (clr && en) begin
                        clr_state <= CLEAR;
                        clr_cnt   <= '0;
                        clr_busy  <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (clr_cnt == LAST_ADDR) begin
                        clr_state <= IDLE;
                        clr_cnt   <= '0;
                        clr_busy  <= 1'b0;
                    end else begin
                        clr_cnt <= clr_cnt + ADDR_W'(1);
                    end
                end
                default: begin
                    clr_state <= IDLE;
                    clr_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Array write port; the clear sweep owns the port while busy, so user
    // writes and clear writes never meet on the same edge.
    always_ff @(posedge wclk) begin
        if (clr_state == CLEAR) begin
            mem[clr_cnt] <= '0;
        end else if (w_accept) begin
            for (int unsigned i = 0; i < NBYTES; i++) begin
                if (wbe[i]) begin
                    mem[w_addr][8*i +: 8] <= w_data[8*i +: 8];
                end
            end
        end
    end

    // First read stage; data holds on idle cycles, valid is per request.
    always_ff @(posedge rclk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data1  <= '0;
            rd_valid1 <= 1'b0;
        end else begin
            rd_valid1 <= r_accept;
            if (r_accept) begin
                rd_data1 <= rd_word;
            end
        end
    end

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            // Extra output register; valid travels with its data.
            always_ff @(posedge rclk or negedge rst_n) begin
                if (!rst_n) begin
                    o_data <= '0;
                    valid  <= 1'b0;
                end else begin
                    valid <= rd_valid1;
                    if (rd_valid1) begin
                        o_data <= rd_data1;
                    end
                end
            end
        end else begin : g_lat1
            assign o_data = rd_data1;
            assign valid  = rd_valid1;
        end
    endgenerate

endmodule

// File: tb/tb_dual_port_ram_be.sv
// Bench for dual_port_ram_be: two instances (read latency 1 and 2) share the
// same stimulus; a reference array plus per-instance expectation queues
// check every read slot.
module tb_dual_port_ram_be;

    localparam int unsigned DW  = 32;
    localparam int unsigned DEP = 20;
    localparam int unsigned AW  = 5;
    localparam int unsigned NB  = 4;

    typedef struct packed {
        logic          v;
        logic          chk;
        logic [DW-1:0] d;
    } exp_t;

    logic          rclk  = 1'b0;
    logic          wclk  = 1'b0;
    logic          rst_n = 1'b1;
    logic          en;
    logic          we;
    logic [NB-1:0] wbe;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_data;
    logic          clr;
    logic          re;
    logic [AW-1:0] r_addr;

    logic          busy1, busy2;
    logic [DW-1:0] data1, data2;
    logic          valid1, valid2;

    int            total = 0;
    int            bad   = 0;
    logic [DW-1:0] model [DEP];
    exp_t          q1 [$];
    exp_t          q2 [$];

    always #6 rclk = ~rclk;
    always #5 wclk = ~wclk;

    dual_port_ram_be #(
        .DATA_W(DW), .DEPTH(DEP), .ADDR_W(AW), .READ_LATENCY(1), .NBYTES(NB)
    ) u_l1 (
        .rclk(rclk), .wclk(wclk), .rst_n(rst_n), .en(en), .we(we), .wbe(wbe),
        .w_addr(w_addr), .w_data(w_data), .clr(clr), .clr_busy(busy1),
        .re(re), .r_addr(r_addr), .o_data(data1), .valid(valid1)
    );

    dual_port_ram_be #(
        .DATA_W(DW), .DEPTH(DEP), .ADDR_W(AW), .READ_LATENCY(2), .NBYTES(NB)
    ) u_l2 (
        .rclk(rclk), .wclk(wclk), .rst_n(rst_n), .en(en), .we(we), .wbe(wbe),
        .w_addr(w_addr), .w_data(w_data), .clr(clr), .clr_busy(busy2),
        .re(re), .r_addr(r_addr), .o_data(data2), .valid(valid2)
    );

    task automatic chk_eq(input string tag, input logic [DW-1:0] obs,
                          input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic e, input logic w, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input logic [NB-1:0] be);
        @(negedge wclk);
        en = e; we = w; w_addr = a; w_data = d; wbe = be;
        @(posedge wclk);
        #1;
        we = 1'b0;
        if (e && w && (a < DEP)) begin
            for (int i = 0; i < NB; i++) begin
                if (be[i]) model[a][8*i +: 8] = d[8*i +: 8];
            end
        end
    endtask

    task automatic rd(input logic e, input logic r, input logic [AW-1:0] a,
                      input logic c);
        exp_t x;
        exp_t y;
        @(negedge rclk);
        en = e; re = r; r_addr = a;
        x.v   = e && r;
        x.chk = c;
        x.d   = '0;
        if (a < DEP) x.d = model[a];
        q1.push_back(x);
        q2.push_back(x);
        @(posedge rclk);
        #1;
        y = q1.pop_front();
        chk_eq("l1_valid", DW'(valid1), DW'(y.v));
        if (y.v && y.chk) chk_eq("l1_data", data1, y.d);
        if (q2.size() >= 2) begin
            y = q2.pop_front();
            chk_eq("l2_valid", DW'(valid2), DW'(y.v));
            if (y.v && y.chk) chk_eq("l2_data", data2, y.d);
        end
    endtask

    task automatic flush();
        rd(1'b1, 1'b0, '0, 1'b0);
        rd(1'b1, 1'b0, '0, 1'b0);
        q1.delete();
        q2.delete();
    endtask

    task automatic chk_reset_outs(input string tag);
        chk_eq({tag, "_busy1"},  DW'(busy1),  '0);
        chk_eq({tag, "_busy2"},  DW'(busy2),  '0);
        chk_eq({tag, "_valid1"}, DW'(valid1), '0);
        chk_eq({tag, "_valid2"}, DW'(valid2), '0);
        chk_eq({tag, "_data1"},  data1,       '0);
        chk_eq({tag, "_data2"},  data2,       '0);
    endtask

    initial begin
        int cnt;
        int k;
        en = 1'b0; we = 1'b0; re = 1'b0; clr = 1'b0;
        wbe = '0; w_addr = '0; w_data = '0; r_addr = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge rclk);
        #1;
        chk_reset_outs("reset");
        @(negedge wclk);
        rst_n = 1'b1;
        en    = 1'b1;

        // Known background: every word all-ones.
        for (int a = 0; a < DEP; a++) wr(1'b1, 1'b1, AW'(a), 32'hFFFF_FFFF, 4'hF);

        // Single-lane write then read with idle cycles after.
        wr(1'b1, 1'b1, 5'd3, 32'h0000_00A5, 4'b0001);
        rd(1'b1, 1'b1, 5'd3, 1'b1);
        flush();

        // Byte-lane merge.
        wr(1'b1, 1'b1, 5'd7, 32'h1122_3344, 4'hF);
        wr(1'b1, 1'b1, 5'd7, 32'hAABB_CCDD, 4'b0101);
        rd(1'b1, 1'b1, 5'd7, 1'b1);
        flush();

        // Back-to-back reads, then a gap, then one more.
        wr(1'b1, 1'b1, 5'd0, 32'd5, 4'hF);
        wr(1'b1, 1'b1, 5'd1, 32'd6, 4'hF);
        wr(1'b1, 1'b1, 5'd2, 32'd7, 4'hF);
        rd(1'b1, 1'b1, 5'd0, 1'b1);
        rd(1'b1, 1'b1, 5'd1, 1'b1);
        rd(1'b1, 1'b1, 5'd2, 1'b1);
        rd(1'b1, 1'b0, 5'd0, 1'b0);
        rd(1'b1, 1'b1, 5'd2, 1'b1);
        flush();

        // Dropped writes: en low, wbe zero, out of range; disabled read.
        wr(1'b0, 1'b1, 5'd19, 32'h0, 4'hF);
        wr(1'b1, 1'b1, 5'd5, 32'h0, 4'h0);
        wr(1'b1, 1'b1, 5'd25, 32'h1234_5678, 4'hF);
        rd(1'b0, 1'b1, 5'd19, 1'b1);
        rd(1'b1, 1'b1, 5'd25, 1'b1);
        rd(1'b1, 1'b1, 5'd19, 1'b1);
        rd(1'b1, 1'b1, 5'd5, 1'b1);
        rd(1'b1, 1'b1, 5'd31, 1'b1);
        flush();

        // Clear sweep with a blocked user write and an ignored re-trigger.
        @(negedge wclk);
        en = 1'b1; clr = 1'b1;
        @(posedge wclk);
        #1;
        clr = 1'b0;
        chk_eq("clr_start_busy1", DW'(busy1), 32'd1);
        chk_eq("clr_start_busy2", DW'(busy2), 32'd1);
        cnt = 1;
        k   = 0;
        while (busy1 && k < 100) begin
            k++;
            @(negedge wclk);
            we = (k == 10); w_addr = 5'd4; w_data = 32'hDEAD_BEEF; wbe = 4'hF;
            clr = (k == 12);
            @(posedge wclk);
            #1;
            we = 1'b0; clr = 1'b0;
            if (busy1) cnt++;
        end
        chk_eq("clr_busy_len", DW'(cnt), 32'd20);
        chk_eq("clr_end_busy2", DW'(busy2), '0);
        for (int a = 0; a < DEP; a++) model[a] = '0;
        for (int a = 0; a < DEP; a++) rd(1'b1, 1'b1, AW'(a), 1'b1);
        flush();

        // Reset in the middle of a clear sweep.
        for (int a = 0; a < DEP; a++) wr(1'b1, 1'b1, AW'(a), 32'hFFFF_FFFF, 4'hF);
        rd(1'b1, 1'b1, 5'd15, 1'b1);
        flush();
        @(negedge wclk);
        clr = 1'b1;
        @(posedge wclk);
        #1;
        clr = 1'b0;
        repeat (10) @(posedge wclk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outs("abort");
        @(negedge wclk);
        rst_n = 1'b1;
        repeat (2) @(posedge wclk);
        #1;
        chk_eq("abort_idle_busy1", DW'(busy1), '0);
        for (int a = 0; a < 10; a++) model[a] = '0;
        for (int a = 0; a < DEP; a++) rd(1'b1, 1'b1, AW'(a), (a != 10));
        flush();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
